// File: rtl/ascon_pkg.sv
// ASCON-128 shared types: permutation state, IV, round constant, FSM states.
package ascon_pkg;

  typedef logic [4:0][63:0] state_t;

  localparam logic [63:0] IV   = 64'h80400C0600000000;
  localparam state_t      DSEP = 320'd1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    AD_WAIT,
    AD_PERM,
    PT_WAIT,
    PT_HOLD,
    PT_PERM,
    FINAL
  } fsm_e;

  function automatic logic [63:0] rc(input logic [3:0] i);
    return {56'h0, 4'hF - i, i};
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x,
                                      input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant, bit-sliced S-box, linear layer.
module ascon_round
  import ascon_pkg::*;
(
  input  state_t     s_i,
  input  logic [3:0] rnd_i,
  output state_t     s_o
);

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;

  // x0 lives in the top word of the packed state
  always_comb begin
    a0 = s_i[4] ^ s_i[0];
    a1 = s_i[3];
    a2 = s_i[2] ^ rc(rnd_i) ^ s_i[3];
    a3 = s_i[1];
    a4 = s_i[0] ^ s_i[1];
    b0 = a0 ^ (~a1 & a2);
    b1 = a1 ^ (~a2 & a3);
    b2 = a2 ^ (~a3 & a4);
    b3 = a3 ^ (~a4 & a0);
    b4 = a4 ^ (~a0 & a1);
    c0 = b0 ^ b4;
    c1 = b1 ^ b0;
    c2 = ~b2;
    c3 = b3 ^ b2;
    c4 = b4;
  end

  assign s_o[4] = c0 ^ ror(c0, 19) ^ ror(c0, 28);
  assign s_o[3] = c1 ^ ror(c1, 61) ^ ror(c1, 39);
  assign s_o[2] = c2 ^ ror(c2, 1)  ^ ror(c2, 6);
  assign s_o[1] = c3 ^ ror(c3, 10) ^ ror(c3, 17);
  assign s_o[0] = c4 ^ ror(c4, 7)  ^ ror(c4, 41);

endmodule

// File: rtl/ascon_aead128.sv
// ASCON-128 AEAD encryption core, one round per clock.
// Define ASCON_UNROLL2_EN for two rounds per clock.
module ascon_aead128
  import ascon_pkg::*;
(
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         init_i,
  input  logic         associate_data_i,
  input  logic         finalisation_i,
  input  logic [63:0]  data_i,
  input  logic         data_valid_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  output logic         end_initialisation_o,
  output logic         end_associate_o,
  output logic [63:0]  cipher_o,
  output logic         cipher_valid_o,
  output logic         end_cipher_o,
  output logic [127:0] tag_o,
  output logic         end_tag_o
);

  fsm_e         st_q;
  state_t       s_q;
  logic [127:0] key_q;
  logic [3:0]   rnd_q;
  state_t       r_o;
  logic         last;
  logic [63:0]  x0_d;
  state_t       abs_d;
  state_t       fin_d;

`ifdef ASCON_UNROLL2_EN
  localparam logic [3:0] STEP = 4'd2;
  state_t r_mid;
  ascon_round u_r0 (.s_i(s_q),   .rnd_i(rnd_q),        .s_o(r_mid));
  ascon_round u_r1 (.s_i(r_mid), .rnd_i(rnd_q + 4'd1), .s_o(r_o));
`else
  localparam logic [3:0] STEP = 4'd1;
  ascon_round u_r0 (.s_i(s_q), .rnd_i(rnd_q), .s_o(r_o));
`endif

  assign last = (rnd_q + STEP == 4'd12);

  always_comb begin
    x0_d  = s_q[4] ^ data_i;
    abs_d = {x0_d, s_q[3:0]};
    fin_d = {s_q[4], s_q[3] ^ key_q[127:64],
             s_q[2] ^ key_q[63:0], s_q[1:0]};
  end

  always_ff @(posedge clock_i) begin
    end_initialisation_o <= 1'b0;
    end_associate_o      <= 1'b0;
    cipher_valid_o       <= 1'b0;
    end_cipher_o         <= 1'b0;
    end_tag_o            <= 1'b0;
    if (!reset_i) begin
      st_q     <= IDLE;
      s_q      <= '0;
      key_q    <= '0;
      rnd_q    <= '0;
      cipher_o <= '0;
      tag_o    <= '0;
    end else begin
      unique case (st_q)
        IDLE: if (init_i) begin
          key_q <= key_i;
          s_q   <= {IV, key_i, nonce_i};
          tag_o <= '0;
          rnd_q <= '0;
          st_q  <= INIT;
        end
        INIT: begin
          s_q   <= last ? (r_o ^ {192'd0, key_q}) : r_o;
          rnd_q <= rnd_q + STEP;
          if (last) begin
            end_initialisation_o <= 1'b1;
            st_q <= AD_WAIT;
          end
        end
        AD_WAIT: begin
          if (finalisation_i) begin
            s_q   <= fin_d ^ DSEP;
            rnd_q <= '0;
            st_q  <= FINAL;
          end else if (data_valid_i && associate_data_i) begin
            s_q   <= abs_d;
            rnd_q <= 4'd6;
            st_q  <= AD_PERM;
          end else if (data_valid_i) begin
            s_q            <= abs_d ^ DSEP;
            cipher_o       <= x0_d;
            cipher_valid_o <= 1'b1;
            rnd_q          <= 4'd6;
            st_q           <= PT_HOLD;
          end
        end
        AD_PERM: begin
          s_q   <= r_o;
          rnd_q <= rnd_q + STEP;
          if (last) begin
            end_associate_o <= 1'b1;
            st_q <= AD_WAIT;
          end
        end
        PT_WAIT: begin
          if (finalisation_i) begin
            s_q   <= fin_d;
            rnd_q <= '0;
            st_q  <= FINAL;
          end else if (data_valid_i && !associate_data_i) begin
            s_q            <= abs_d;
            cipher_o       <= x0_d;
            cipher_valid_o <= 1'b1;
            rnd_q          <= 4'd6;
            st_q           <= PT_HOLD;
          end
        end
        // first p^6 round already runs on the decision edge
        PT_HOLD: begin
          if (finalisation_i) begin
            s_q   <= fin_d;
            rnd_q <= '0;
            st_q  <= FINAL;
          end else if (data_valid_i) begin
            s_q   <= r_o;
            rnd_q <= rnd_q + STEP;
            st_q  <= PT_PERM;
          end
        end
        PT_PERM: begin
          s_q   <= r_o;
          rnd_q <= rnd_q + STEP;
          if (last) begin
            end_cipher_o <= 1'b1;
            st_q <= PT_WAIT;
          end
        end
        FINAL: begin
          s_q   <= r_o;
          rnd_q <= rnd_q + STEP;
          if (last) begin
            tag_o     <= r_o[1:0] ^ key_q;
            end_tag_o <= 1'b1;
            st_q      <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_aead128.sv
// Self-checking bench for ascon_aead128 against a table-driven ASCON model.
module tb_ascon_aead128;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         init = 1'b0;
  logic         ad = 1'b0;
  logic         fin = 1'b0;
  logic         dv = 1'b0;
  logic [63:0]  data = '0;
  logic [127:0] key = '0;
  logic [127:0] nonce = '0;
  logic         ei, ea, cv, ec, et;
  logic [63:0]  ct;
  logic [127:0] tag;

  always #5 clk = ~clk;

  ascon_aead128 dut (
    .clock_i(clk), .reset_i(rst), .init_i(init),
    .associate_data_i(ad), .finalisation_i(fin),
    .data_i(data), .data_valid_i(dv),
    .key_i(key), .nonce_i(nonce),
    .end_initialisation_o(ei), .end_associate_o(ea),
    .cipher_o(ct), .cipher_valid_o(cv),
    .end_cipher_o(ec), .tag_o(tag), .end_tag_o(et)
  );

`ifdef ASCON_UNROLL2_EN
  localparam int P12 = 6;
  localparam int P6  = 3;
`else
  localparam int P12 = 12;
  localparam int P6  = 6;
`endif

  localparam logic [63:0]  M_IV = 64'h80400C0600000000;
  localparam logic [127:0] KATK = 128'h000102030405060708090A0B0C0D0E0F;

  int n_chk = 0;
  int n_pass = 0;

  // pulse counters sampled mid-high-phase
  int c_ei = 0, c_ea = 0, c_cv = 0, c_ec = 0, c_et = 0, c_long = 0;
  logic [4:0] prev = '0;
  always @(posedge clk) begin
    #2;
    c_ei += int'(ei); c_ea += int'(ea); c_cv += int'(cv);
    c_ec += int'(ec); c_et += int'(et);
    if (|({ei, ea, cv, ec, et} & prev)) c_long++;
    prev = {ei, ea, cv, ec, et};
  end

  int SBOX [32] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                    30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};
  logic [63:0]  m [5];
  logic [63:0]  ad_q[$], pt_q[$], ct_exp[$], ct_got[$];
  logic [127:0] tag_exp, tag_got;
  logic [63:0]  inj_ct;
  int l_init, l_tag, ad_min, ad_max, ec_min, ec_max, cv_max, inj_ev;

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  task automatic m_perm(input int nr);
    logic [4:0]  col, o;
    logic [63:0] t [5];
    for (int r = 12 - nr; r < 12; r++) begin
      m[2] ^= 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        col = {m[0][b], m[1][b], m[2][b], m[3][b], m[4][b]};
        o = 5'(SBOX[col]);
        for (int j = 0; j < 5; j++) t[j][b] = o[4-j];
      end
      m[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
      m[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
      m[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
      m[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
      m[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
    end
  endtask

  task automatic m_encrypt(input logic [127:0] k, input logic [127:0] n);
    m[0] = M_IV; m[1] = k[127:64]; m[2] = k[63:0];
    m[3] = n[127:64]; m[4] = n[63:0];
    m_perm(12);
    m[3] ^= k[127:64]; m[4] ^= k[63:0];
    foreach (ad_q[i]) begin
      m[0] ^= ad_q[i];
      m_perm(6);
    end
    m[4] ^= 64'd1;
    ct_exp.delete();
    foreach (pt_q[i]) begin
      m[0] ^= pt_q[i];
      ct_exp.push_back(m[0]);
      if (i != pt_q.size() - 1) m_perm(6);
    end
    m[1] ^= k[127:64]; m[2] ^= k[63:0];
    m_perm(12);
    tag_exp = {m[3], m[4]} ^ k;
  endtask

  task automatic wait_evt(input int which, input int first, output int lat);
    logic s;
    lat = -1;
    for (int c = first; c < first + 40; c++) begin
      @(negedge clk);
      case (which)
        0: s = ei;
        1: s = ea;
        2: s = cv;
        3: s = ec;
        default: s = et;
      endcase
      if (s) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      n_chk++;
      $display("FAIL timeout event=%0d got no pulse, required one", which);
    end
  endtask

  task automatic clr_stats();
    ad_min = 99; ad_max = -99; ec_min = 99; ec_max = -99; cv_max = -99;
    c_long = 0;
  endtask

  task automatic run_msg(input logic [127:0] k, input logic [127:0] n,
                         input bit inject);
    int lat, snap;
    ct_got.delete();
    @(negedge clk);
    rst = 1'b1; key = k; nonce = n; init = 1'b1;
    wait_evt(0, 0, lat);
    init = 1'b0; l_init = lat; key = r128(); nonce = r128();
    foreach (ad_q[i]) begin
      data = ad_q[i]; ad = 1'b1; dv = 1'b1;
      wait_evt(1, 0, lat);
      if (lat < ad_min) ad_min = lat;
      if (lat > ad_max) ad_max = lat;
      dv = 1'b0; ad = 1'b0;
    end
    foreach (pt_q[i]) begin
      data = pt_q[i]; ad = 1'b0; dv = 1'b1;
      wait_evt(2, 0, lat);
      if (lat > cv_max) cv_max = lat;
      ct_got.push_back(ct);
      if (i == pt_q.size() - 1) begin
        dv = 1'b0; fin = 1'b1;
      end else begin
        wait_evt(3, 1, lat);
        if (lat < ec_min) ec_min = lat;
        if (lat > ec_max) ec_max = lat;
        dv = 1'b0;
        if (inject && i == 0) begin
          snap = c_ei + c_ea + c_cv + c_ec + c_et;
          data = r64(); ad = 1'b1; dv = 1'b1;
          init = 1'b1; key = r128(); nonce = r128();
          repeat (8) @(negedge clk);
          ad = 1'b0; dv = 1'b0; init = 1'b0;
          inj_ev = c_ei + c_ea + c_cv + c_ec + c_et - snap;
          inj_ct = ct;
        end
      end
    end
    wait_evt(4, 0, lat);
    fin = 1'b0; l_tag = lat; tag_got = tag; data = r64();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    int b_ei;
    logic [127:0] k, n;
    rst = 1'b0; init = 1'b0; dv = 1'b0; ad = 1'b0; fin = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({ei, ea, cv, ec, et, ct, tag} !== '0)
      $display("FAIL reset_outputs got %h required 0", {ei, ea, cv, ec, et, ct, tag});
    else n_pass++;
    ad_q.delete(); pt_q.delete();
    pt_q.push_back(r64()); pt_q.push_back(r64());
    run_msg(r128(), r128(), 1'b0);
    @(negedge clk);
    key = r128(); nonce = r128(); init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (3) @(negedge clk);
    b_ei = c_ei;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({ei, ea, cv, ec, et, ct, tag} !== '0)
      $display("FAIL reset_mid_init got %h required 0", {ei, ea, cv, ec, et, ct, tag});
    else n_pass++;
    k = r128(); n = r128();
    pt_q.delete(); pt_q.push_back(r64());
    m_encrypt(k, n);
    run_msg(k, n, 1'b0);
    n_chk++;
    if (l_init !== P12) $display("FAIL reset_reinit_lat got %0d required %0d", l_init, P12);
    else n_pass++;
    n_chk++;
    if (c_ei - b_ei !== 1) $display("FAIL reset_ei_count got %0d required 1", c_ei - b_ei);
    else n_pass++;
    n_chk++;
    if (tag_got !== tag_exp) $display("FAIL reset_tag got %h required %h", tag_got, tag_exp);
    else n_pass++;
  endtask

  task automatic test_kat;
    ad_q.delete(); pt_q.delete();
    pt_q.push_back(64'h8000000000000000);
    m_encrypt(KATK, KATK);
    run_msg(KATK, KATK, 1'b0);
    n_chk++;
    if (tag_got !== 128'hE355159F292911F794CB1432A0103A8A)
      $display("FAIL kat_tag got %h required E355159F292911F794CB1432A0103A8A", tag_got);
    else n_pass++;
    n_chk++;
    if (ct_got[0] !== ct_exp[0]) $display("FAIL kat_ct got %h required %h", ct_got[0], ct_exp[0]);
    else n_pass++;
  endtask

  task automatic test_timing;
    logic [127:0] k, n;
    k = r128(); n = r128();
    ad_q.delete(); pt_q.delete();
    repeat (2) ad_q.push_back(r64());
    repeat (3) pt_q.push_back(r64());
    m_encrypt(k, n);
    clr_stats();
    run_msg(k, n, 1'b0);
    n_chk++;
    if (l_init !== P12) $display("FAIL t_init got %0d required %0d", l_init, P12);
    else n_pass++;
    n_chk++;
    if (ad_min !== P6 || ad_max !== P6)
      $display("FAIL t_assoc got %0d..%0d required %0d", ad_min, ad_max, P6);
    else n_pass++;
    n_chk++;
    if (ec_min !== P6 || ec_max !== P6)
      $display("FAIL t_cipher got %0d..%0d required %0d", ec_min, ec_max, P6);
    else n_pass++;
    n_chk++;
    if (cv_max !== 0) $display("FAIL t_cvalid got %0d required 0", cv_max);
    else n_pass++;
    n_chk++;
    if (l_tag !== P12) $display("FAIL t_tag got %0d required %0d", l_tag, P12);
    else n_pass++;
    n_chk++;
    if (c_long !== 0) $display("FAIL t_pulse_width got %0d long pulses required 0", c_long);
    else n_pass++;
    n_chk++;
    if (tag_got !== tag_exp) $display("FAIL t_tagval got %h required %h", tag_got, tag_exp);
    else n_pass++;
  endtask

  task automatic test_full_message;
    int b_cv, b_ec, b_et;
    logic [127:0] k, n;
    k = 128'h8A55114D1CB6A9A2BE263D4D7AECAAFF;
    n = 128'h4ED0EC0B98C529B7C8CDDF37BCD0284A;
    ad_q.delete(); pt_q.delete();
    ad_q.push_back(64'h4120746F20428000);
    repeat (22) pt_q.push_back(r64());
    pt_q.push_back({8'($urandom), 8'($urandom), 8'($urandom), 8'h80, 32'h0});
    m_encrypt(k, n);
    b_cv = c_cv; b_ec = c_ec; b_et = c_et;
    run_msg(k, n, 1'b0);
    n_chk++;
    if (c_cv - b_cv !== 23 || c_ec - b_ec !== 22 || c_et - b_et !== 1)
      $display("FAIL full_counts got cv=%0d ec=%0d et=%0d required 23/22/1",
               c_cv - b_cv, c_ec - b_ec, c_et - b_et);
    else n_pass++;
    foreach (ct_exp[i]) begin
      n_chk++;
      if (ct_got.size() <= i || ct_got[i] !== ct_exp[i])
        $display("FAIL full_ct[%0d] got %h required %h", i,
                 (ct_got.size() > i) ? ct_got[i] : 64'hx, ct_exp[i]);
      else n_pass++;
    end
    n_chk++;
    if (tag_got !== tag_exp) $display("FAIL full_tag got %h required %h", tag_got, tag_exp);
    else n_pass++;
  endtask

  task automatic test_ad_variants;
    logic [127:0] k, n;
    for (int v = 0; v < 2; v++) begin
      k = r128(); n = r128();
      ad_q.delete(); pt_q.delete();
      if (v == 0) repeat (2) ad_q.push_back(r64());
      repeat (3 - v) pt_q.push_back(r64());
      m_encrypt(k, n);
      run_msg(k, n, 1'b0);
      foreach (ct_exp[i]) begin
        n_chk++;
        if (ct_got.size() <= i || ct_got[i] !== ct_exp[i])
          $display("FAIL adv%0d_ct[%0d] got %h required %h", v, i,
                   (ct_got.size() > i) ? ct_got[i] : 64'hx, ct_exp[i]);
        else n_pass++;
      end
      n_chk++;
      if (tag_got !== tag_exp) $display("FAIL adv%0d_tag got %h required %h", v, tag_got, tag_exp);
      else n_pass++;
    end
  endtask

  task automatic test_protocol;
    logic [127:0] k, n;
    k = r128(); n = r128();
    ad_q.delete(); pt_q.delete();
    ad_q.push_back(r64());
    repeat (3) pt_q.push_back(r64());
    m_encrypt(k, n);
    run_msg(k, n, 1'b1);
    n_chk++;
    if (inj_ev !== 0) $display("FAIL prot_events got %0d pulses required 0", inj_ev);
    else n_pass++;
    n_chk++;
    if (inj_ct !== ct_exp[0]) $display("FAIL prot_ct_held got %h required %h", inj_ct, ct_exp[0]);
    else n_pass++;
    n_chk++;
    if (ct_got[2] !== ct_exp[2]) $display("FAIL prot_ct2 got %h required %h", ct_got[2], ct_exp[2]);
    else n_pass++;
    n_chk++;
    if (tag_got !== tag_exp) $display("FAIL prot_tag got %h required %h", tag_got, tag_exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [127:0] k, n;
    int bad;
    for (int r = 0; r < 4; r++) begin
      k = r128(); n = r128();
      ad_q.delete(); pt_q.delete();
      repeat ($urandom_range(0, 2)) ad_q.push_back(r64());
      repeat ($urandom_range(1, 4)) pt_q.push_back(r64());
      m_encrypt(k, n);
      run_msg(k, n, 1'b0);
      bad = (ct_got.size() != ct_exp.size()) ? 1 : 0;
      foreach (ct_exp[i]) if (ct_got.size() > i && ct_got[i] !== ct_exp[i]) bad++;
      n_chk++;
      if (bad !== 0) $display("FAIL b2b%0d_ct got %0d bad blocks required 0", r, bad);
      else n_pass++;
      n_chk++;
      if (tag_got !== tag_exp) $display("FAIL b2b%0d_tag got %h required %h", r, tag_got, tag_exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_kat();
    test_timing();
    test_full_message();
    test_ad_variants();
    test_protocol();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
